// File: rtl/mux_sel_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mux_sel_arbiter_pkg
// Shared definitions for the two-requester mux-select arbiter:
//   - arb_state_e : grant state encoding (IDLE / G0 / G1)
//   - HOLD_MAX_DEFAULT, CW_DEFAULT : default hold limit and counter width
//   - arb_decide() : round-robin pick between two requesters
// -----------------------------------------------------------------------------
package mux_sel_arbiter_pkg;

  // One-hot-ish encoding: bit 0 means requester 0 owns the port, bit 1 means
  // requester 1 owns it. 2'b11 is illegal and is treated as IDLE by the FSM.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    G0   = 2'b01,
    G1   = 2'b10
  } arb_state_e;

  localparam int HOLD_MAX_DEFAULT = 8;
  localparam int CW_DEFAULT       = 4;

  // Round-robin decision. last_grant = 0 means requester 0 was granted most
  // recently, so on a tie requester 1 wins, and vice versa.
  function automatic arb_state_e arb_decide(input logic req0,
                                            input logic req1,
                                            input logic last_grant);
    arb_state_e pick;
    if (req0 && req1) begin
      pick = last_grant ? G0 : G1;
    end else if (req0) begin
      pick = G0;
    end else if (req1) begin
      pick = G1;
    end else begin
      pick = IDLE;
    end
    return pick;
  endfunction

endpackage

// File: rtl/mux_sel_arbiter_hold_counter.sv
// -----------------------------------------------------------------------------
// mux_sel_arbiter_hold_counter
// CW-bit saturating up-counter used to measure how long the current owner has
// held the shared port.
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset, clears the count
//   clr_i     : synchronous clear (wins over en_i)
//   en_i      : count enable; the count stops at MAX_VAL
//   at_max_o  : high while the count equals MAX_VAL (terminal count)
// -----------------------------------------------------------------------------
module mux_sel_arbiter_hold_counter #(
  parameter int CW      = 4,
  parameter int MAX_VAL = 7
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic at_max_o
);

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_VAL);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != MAX_CNT)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign at_max_o = (count_q == MAX_CNT);

endmodule

// File: rtl/mux_sel_arbiter.sv
// -----------------------------------------------------------------------------
// mux_sel_arbiter
// Two-requester round-robin arbiter in front of a 2:1 mux that shares one
// datapath port. Exactly one requester is granted at a time, the mux select
// comes straight from a flop, and a hold counter forces the owner off the port
// after HOLD_MAX consecutive cycles when the other requester is waiting.
//
// Ports
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset
//   req0/1  : level request, held for the whole transaction
//   done0/1 : last cycle of the owner's transaction (ignored unless granted)
//   gnt0/1  : registered grants, never both high
//   sel     : registered mux select (0 = requester 0, 1 = requester 1);
//             keeps its last value while idle
//   busy    : registered gnt0 | gnt1
//   timeout : one-cycle pulse in the first cycle after a forced release
// -----------------------------------------------------------------------------
import mux_sel_arbiter_pkg::*;

module mux_sel_arbiter #(
  parameter int HOLD_MAX = HOLD_MAX_DEFAULT,
  parameter int CW       = CW_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  input  logic done0,
  input  logic done1,
  output logic gnt0,
  output logic gnt1,
  output logic sel,
  output logic busy,
  output logic timeout
);

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  arb_state_e state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic       gnt0_q, gnt0_d;
  logic       gnt1_q, gnt1_d;
  logic       sel_q, sel_d;
  logic       busy_q, busy_d;
  logic       timeout_q, timeout_d;

  // Decision helpers
  logic decide;       // re-run arbitration at this edge
  logic voluntary;    // owner finished or withdrew its request
  logic forced;       // owner hit the hold limit while the other is waiting
  logic cnt_clr;
  logic cnt_en;
  logic cnt_at_max;

  // ---------------------------------------------------------------------------
  // Hold counter: counts granted cycles of the current owner. It reads 0 in
  // the first granted cycle, so reaching HOLD_MAX-1 means the owner has been
  // on the port for HOLD_MAX cycles.
  // ---------------------------------------------------------------------------
  mux_sel_arbiter_hold_counter #(
    .CW      (CW),
    .MAX_VAL (HOLD_MAX - 1)
  ) u_hold_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (cnt_clr),
    .en_i     (cnt_en),
    .at_max_o (cnt_at_max)
  );

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    decide       = 1'b0;
    voluntary    = 1'b0;
    forced       = 1'b0;
    cnt_clr      = 1'b0;
    cnt_en       = 1'b0;

    case (state_q)
      IDLE: begin
        decide = 1'b1;
      end
      G0: begin
        voluntary = done0 | ~req0;
        // A release the owner asked for is never reported as a timeout, even
        // if the hold limit happens to be reached on the same edge.
        forced    = ~voluntary & cnt_at_max & req1;
        decide    = voluntary | forced;
      end
      G1: begin
        voluntary = done1 | ~req1;
        forced    = ~voluntary & cnt_at_max & req0;
        decide    = voluntary | forced;
      end
      default: begin
        decide = 1'b1;
      end
    endcase

    if (decide) begin
      // Release and re-arbitration happen on the same edge, so a handoff has
      // no idle bubble and a lone re-requester is re-granted with a fresh
      // count.
      state_d = arb_decide(req0, req1, last_grant_q);
      cnt_clr = 1'b1;
      if (state_d == G0) begin
        last_grant_d = 1'b0;
      end else if (state_d == G1) begin
        last_grant_d = 1'b1;
      end
    end else begin
      cnt_en = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Output next values, all taken from the next state so every output is a
  // flop and the mux select cannot glitch.
  // ---------------------------------------------------------------------------
  always_comb begin
    gnt0_d    = (state_d == G0);
    gnt1_d    = (state_d == G1);
    busy_d    = (state_d == G0) || (state_d == G1);
    timeout_d = forced;
    sel_d     = sel_q;
    if (state_d == G1) begin
      sel_d = 1'b1;
    end else if (state_d == G0) begin
      sel_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;   // requester 0 wins the first tie
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      sel_q        <= 1'b0;
      busy_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt0_q       <= gnt0_d;
      gnt1_q       <= gnt1_d;
      sel_q        <= sel_d;
      busy_q       <= busy_d;
      timeout_q    <= timeout_d;
    end
  end

  assign gnt0    = gnt0_q;
  assign gnt1    = gnt1_q;
  assign sel     = sel_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux_sel_arbiter
// Directed scenarios followed by randomized traffic, each cycle compared
// against a behavioural model that tracks the owner and how many cycles it
// has held the port.
// -----------------------------------------------------------------------------
module tb_mux_sel_arbiter;

  localparam int HOLD_MAX = 8;
  localparam int CW       = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic req0 = 1'b0, req1 = 1'b0, done0 = 1'b0, done1 = 1'b0;
  logic gnt0, gnt1, sel, busy, timeout;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int cyc      = 0;

  // Reference model state
  int m_owner;     // -1 = nobody, 0 or 1 = owning requester
  int m_held;      // cycles the current owner has held the port, unbounded
  bit m_last;      // requester granted most recently
  bit m_sel;
  bit m_timeout;

  mux_sel_arbiter #(
    .HOLD_MAX (HOLD_MAX),
    .CW       (CW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req0    (req0),
    .req1    (req1),
    .done0   (done0),
    .done1   (done1),
    .gnt0    (gnt0),
    .gnt1    (gnt1),
    .sel     (sel),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] obs_vec();
    return {27'd0, gnt0, gnt1, sel, busy, timeout};
  endfunction

  function automatic logic [31:0] exp_vec();
    return {27'd0, (m_owner == 0), (m_owner == 1), m_sel, (m_owner >= 0), m_timeout};
  endfunction

  task automatic model_reset();
    m_owner   = -1;
    m_held    = 0;
    m_last    = 1'b1;
    m_sel     = 1'b0;
    m_timeout = 1'b0;
  endtask

  // One rising edge worth of arbitration rules.
  task automatic model_edge(input bit r0, input bit r1, input bit d0, input bit d1);
    bit rearb;
    bit frc;
    bit own_req, own_done, other_req;
    int pick;
    rearb = 1'b0;
    frc   = 1'b0;
    if (m_owner < 0) begin
      rearb = 1'b1;
    end else begin
      own_req   = (m_owner == 0) ? r0 : r1;
      own_done  = (m_owner == 0) ? d0 : d1;
      other_req = (m_owner == 0) ? r1 : r0;
      if (own_done || !own_req) begin
        rearb = 1'b1;
      end else if (m_held >= HOLD_MAX && other_req) begin
        rearb = 1'b1;
        frc   = 1'b1;
      end
    end
    if (rearb) begin
      if (r0 && r1)  pick = (m_last == 1'b0) ? 1 : 0;
      else if (r0)   pick = 0;
      else if (r1)   pick = 1;
      else           pick = -1;
      m_owner = pick;
      if (pick >= 0) begin
        m_last = (pick == 1);
        m_held = 1;
      end else begin
        m_held = 0;
      end
    end else begin
      m_held++;
    end
    m_timeout = frc;
    if (m_owner == 0) m_sel = 1'b0;
    else if (m_owner == 1) m_sel = 1'b1;
  endtask

  // Drive one cycle of inputs, let the edge happen, then compare on the
  // falling edge.
  task automatic step(input bit r0, input bit r1, input bit d0, input bit d1);
    req0  = r0;
    req1  = r1;
    done0 = d0;
    done1 = d1;
    @(posedge clk);
    model_edge(r0, r1, d0, d1);
    @(negedge clk);
    cyc++;
    check($sformatf("cyc%0d_outs", cyc), obs_vec(), exp_vec());
    $display("cyc %0d req=%b%b done=%b%b -> gnt=%b%b sel=%b busy=%b timeout=%b",
             cyc, r0, r1, d0, d1, gnt0, gnt1, sel, busy, timeout);
  endtask

  task automatic do_reset();
    @(negedge clk);
    req0  = 1'b0;
    req1  = 1'b0;
    done0 = 1'b0;
    done1 = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check("reset_outs", obs_vec(), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int n_gnt0;
    int n_to;
    int n_idle;
    int grants[$];
    bit pg0, pg1;
    bit r0, r1;

    model_reset();

    // --- Single requester with done ---------------------------------------
    do_reset();
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    check("s1_grant", {29'd0, gnt0, sel, busy}, {29'd0, 1'b1, 1'b0, 1'b1});
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);   // done and req fall together: one release
    check("s1_release", {30'd0, gnt0, busy}, 32'd0);
    step(0, 0, 0, 0);

    // --- Back-to-back handoff ---------------------------------------------
    do_reset();
    step(1, 1, 0, 0);
    check("s2_first_gnt0", {31'd0, gnt0}, 32'd1);
    step(1, 1, 1, 0);
    check("s2_handoff", {28'd0, gnt0, gnt1, sel, busy}, {28'd0, 1'b0, 1'b1, 1'b1, 1'b1});
    step(0, 0, 0, 0);

    // --- Round robin, done every 3rd granted cycle ------------------------
    do_reset();
    pg0 = 1'b0;
    pg1 = 1'b0;
    n_idle = 0;
    grants.delete();
    for (int k = 1; k <= 18; k++) begin
      bit dn;
      dn = (k >= 4) && ((k % 3) == 1);
      step(1, 1, dn, dn);
      if (gnt0 && !pg0) grants.push_back(0);
      if (gnt1 && !pg1) grants.push_back(1);
      if (!busy) n_idle++;
      pg0 = gnt0;
      pg1 = gnt1;
    end
    check("rr_grants", grants.size(), 6);
    check("rr_idle", n_idle, 0);
    for (int i = 0; i < grants.size(); i++) begin
      check($sformatf("rr_seq%0d", i), grants[i], i % 2);
    end
    step(0, 0, 0, 0);

    // --- Forced release at HOLD_MAX ---------------------------------------
    do_reset();
    n_gnt0 = 0;
    n_to   = 0;
    for (int k = 1; k <= 12; k++) begin
      step(1, (k >= 4), 0, 0);
      if (gnt0) n_gnt0++;
      if (timeout) n_to++;
      if (k == 9) check("hold_timeout_handoff", {30'd0, gnt1, timeout}, 32'd3);
    end
    check("hold_gnt0_cycles", n_gnt0, HOLD_MAX);
    check("hold_timeout_pulses", n_to, 1);
    step(0, 0, 0, 0);

    // --- Uncontended hold, then late contender ----------------------------
    do_reset();
    n_gnt0 = 0;
    n_to   = 0;
    for (int k = 1; k <= 20; k++) begin
      step(1, 0, 0, 0);
      if (gnt0) n_gnt0++;
      if (timeout) n_to++;
    end
    check("solo_gnt0_cycles", n_gnt0, 20);
    check("solo_no_timeout", n_to, 0);
    step(1, 1, 0, 0);
    check("late_forced", {29'd0, gnt0, gnt1, timeout}, {29'd0, 1'b0, 1'b1, 1'b1});
    step(1, 1, 0, 0);
    check("late_pulse_end", {31'd0, timeout}, 32'd0);
    step(0, 0, 0, 0);

    // --- Asynchronous reset in the middle of G1 ---------------------------
    do_reset();
    step(1, 1, 0, 0);
    step(1, 1, 1, 0);
    step(1, 1, 0, 0);
    check("pre_rst_g1", {31'd0, gnt1}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_outs", obs_vec(), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 1, 0, 0);
    check("midrst_first_gnt", {30'd0, gnt0, gnt1}, 32'd2);
    step(0, 0, 0, 0);

    // --- Randomized traffic -----------------------------------------------
    r0 = 1'b0;
    r1 = 1'b0;
    for (int i = 0; i < 400; i++) begin
      bit d0, d1;
      if ($urandom_range(7) == 0) r0 = ~r0;
      if ($urandom_range(7) == 0) r1 = ~r1;
      d0 = ($urandom_range(11) == 0);
      d1 = ($urandom_range(11) == 0);
      step(r0, r1, d0, d1);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/mux_sel_arbiter.md
Name: mux_sel_arbiter

Overview:
Two-requester round-robin arbiter that shares one datapath resource (a register-file write port or memory port) fronted by a 2:1 mux. It grants exactly one requester at a time and drives the mux select from registered state, so the select never glitches. A per-grant hold counter bounds how long one requester can monopolise the resource when the other is waiting.

Parameters:
HOLD_MAX, 8, maximum consecutive granted cycles before forced release when the other requester is pending (legal range 2..15)
CW, 4, hold counter width; must satisfy 2^CW > HOLD_MAX

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req0  input  1  requester 0 wants the resource; level, held for the whole transaction
req1  input  1  requester 1 wants the resource
done0  input  1  requester 0 finishes its transaction this cycle; ignored unless gnt0=1
done1  input  1  requester 1 finishes its transaction this cycle; ignored unless gnt1=1
gnt0  output  1  requester 0 owns the resource
gnt1  output  1  requester 1 owns the resource
sel  output  1  mux select: 0 = in0/requester 0, 1 = in1/requester 1
busy  output  1  gnt0 | gnt1
timeout  output  1  one-cycle pulse marking a forced release

Behaviour:
- One clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset values, applied immediately on rst_n=0 including mid-grant: state=IDLE, gnt0=0, gnt1=0, sel=0, busy=0, timeout=0, count=0, last_grant=1 (requester 0 wins the first tie).
- States: IDLE, G0, G1. All outputs are registered. gnt0 and gnt1 are never both 1.
- Latency: a req sampled at edge t raises gnt at edge t. gnt is visible in the cycle after req first goes high.
- Arbitration decision, used in IDLE and on every release:
  - If only one req is high, grant that requester.
  - If both are high, grant the one that is not last_grant.
  - If neither is high, go to IDLE.
  - last_grant updates on each new grant.
- Release conditions in Gn, evaluated at each edge:
  - donen=1, or
  - reqn=0, or
  - count=HOLD_MAX-1 while the other req=1 (forced release).
- On release, re-run the decision at the same edge. Handoff is back-to-back with no idle bubble: gnt0 falls and gnt1 rises on one edge.
- If the released requester still requests and the other does not, it is re-granted at once with count cleared.
- count:
  - clears to 0 on every new grant;
  - increments each granted cycle;
  - saturates at HOLD_MAX-1.
- With no contention, the grant is held indefinitely and timeout stays 0. A later req from the other requester forces release at the next edge.
- timeout=1 for exactly the one cycle that follows the forced-release edge, coincident with the new grant.
- sel=1 in G1 and sel=0 in G0. In IDLE, sel holds its last value.
- done and req both falling on the same edge count as a single release.
- done from the non-granted requester has no effect.

Decomposition:
- Shared include file arb_defs.vh: state encodings IDLE=2'b00, G0=2'b01, G1=2'b10, and the default HOLD_MAX.
- One sub-module, hold_counter: CW-bit saturating up-counter with synchronous clear, enable and async active-low reset, plus a flag output for terminal count.

Test Plan:
- Reset released; req0=1 at cycle 2, done0 pulsed at cycle 5 -> gnt0=1 and busy=1 from cycle 3 with sel=0; gnt0=0 and busy=0 from cycle 6.
- req0=req1=1 at cycle 2 -> gnt0=1 at cycle 3; done0 at cycle 4 -> at cycle 5 gnt0=0 and gnt1=1 on the same edge, sel=1, busy stays 1.
- Both req held high, done pulsed every 3rd granted cycle -> grant sequence 0,1,0,1,0,1 with no IDLE cycle between grants.
- HOLD_MAX=8: req0 held with no done, req1 raised in the 3rd granted cycle -> gnt0 high exactly 8 cycles, then gnt1=1 with timeout=1 for one cycle, then timeout=0.
- req0 held alone for 20 cycles, no done -> gnt0 stays 1 throughout, timeout never asserts; req1 raised at cycle 21 -> forced handoff to gnt1 at the next edge, with timeout pulse.
- rst_n driven low between edges during G1 -> gnt1, sel, busy and timeout go 0 immediately; after release with req0=req1=1 -> gnt0 wins the first grant.
